// File: rtl/gpu_buffer_pkg.sv
`default_nettype none
// ============================================================================
// gpu_buffer_pkg : shared entry type and width helper for warp buffers
// Revision 1.0
// ============================================================================
package gpu_buffer_pkg;

   typedef logic [7:0] warp_reg_t;

   // Width needed to encode n distinct values, never less than one bit.
   function automatic int width_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ring_channel.sv
`default_nettype none
// ============================================================================
// ring_channel : one ring queue with head/tail pointers and occupancy count
// Revision 1.0
// ============================================================================
module ring_channel
   import gpu_buffer_pkg::*;
#(
   parameter int  DEPTH = 8,
   parameter type T     = warp_reg_t,
   parameter int  CW    = width_of(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_en,
   input  logic          pop_en,
   input  T              data_in,
   output T              head_data,
   output logic [CW-1:0] count
);

   localparam int PW = width_of(DEPTH);

   T              mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;

   // Explicit wrap so any DEPTH works, not just powers of two.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (push_en) begin
         mem[tail] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push_en) begin
            tail <= next_ptr(tail);
         end
         if (pop_en) begin
            head <= next_ptr(head);
         end
         case ({push_en, pop_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_data = mem[head];

endmodule
`default_nettype wire

// File: rtl/multi_circular_buffer.sv
`default_nettype none
// ============================================================================
// multi_circular_buffer : NUM_CH ring queues behind shared push and read ports
// Revision 1.0
// ============================================================================
module multi_circular_buffer
   import gpu_buffer_pkg::*;
#(
   parameter int  NUM_CH   = 4,
   parameter int  DEPTH    = 8,
   parameter type T        = warp_reg_t,
   parameter int  AF_LEVEL = DEPTH - 1
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       push_buffer,
   input  logic [width_of(NUM_CH)-1:0]                push_ch,
   input  T                                           data_in,
   input  logic                                       pop_buffer,
   input  logic                                       read_buffer,
   input  logic [width_of(NUM_CH)-1:0]                rd_ch,
   input  logic                                       err_clear,
   output T                                           data_out,
   output logic                                       data_valid,
   output logic [NUM_CH-1:0][width_of(DEPTH+1)-1:0]   count,
   output logic [NUM_CH-1:0]                          empty,
   output logic [NUM_CH-1:0]                          at_capacity,
   output logic [NUM_CH-1:0]                          almost_full,
   output logic                                       overflow,
   output logic                                       underflow
);

   localparam int CHW = width_of(NUM_CH);
   localparam int CW  = width_of(DEPTH + 1);

   logic [NUM_CH-1:0] push_en;
   logic [NUM_CH-1:0] pop_en;
   T                  head_data [NUM_CH];
   T                  rd_data;
   logic              rd_active;
   logic              rd_hit;
   logic              push_hit;

   assign rd_active = pop_buffer | read_buffer;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign empty[i]       = (count[i] == '0);
      assign at_capacity[i] = (count[i] == CW'(DEPTH));
      assign almost_full[i] = (count[i] >= CW'(AF_LEVEL));

      // A same-channel pop frees the slot, so a full channel may still accept.
      assign pop_en[i]  = pop_buffer && (rd_ch == CHW'(i)) && !empty[i];
      assign push_en[i] = push_buffer && (push_ch == CHW'(i)) && (!at_capacity[i] || pop_en[i]);

      ring_channel #(
         .DEPTH (DEPTH),
         .T     (T),
         .CW    (CW)
      ) u_ring (
         .clk       (clk),
         .rst       (rst),
         .push_en   (push_en[i]),
         .pop_en    (pop_en[i]),
         .data_in   (data_in),
         .head_data (head_data[i]),
         .count     (count[i])
      );
   end

   // Out-of-range channel numbers match no entry and so count as errors.
   always_comb begin
      rd_hit   = 1'b0;
      push_hit = 1'b0;
      rd_data  = head_data[0];
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_ch == CHW'(i)) begin
            rd_hit  = rd_active && !empty[i];
            rd_data = head_data[i];
         end
         if (push_ch == CHW'(i)) begin
            push_hit = push_en[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         data_valid <= rd_hit;
         if (rd_hit) begin
            data_out <= rd_data;
         end
         if (push_buffer && !push_hit) begin
            overflow <= 1'b1;
         end else if (err_clear) begin
            overflow <= 1'b0;
         end
         if (rd_active && !rd_hit) begin
            underflow <= 1'b1;
         end else if (err_clear) begin
            underflow <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multi_circular_buffer.sv
`default_nettype none
// ============================================================================
// tb_multi_circular_buffer : scoreboard bench for multi_circular_buffer
// Revision 1.0
// ============================================================================
module tb_multi_circular_buffer;
   import gpu_buffer_pkg::*;

   localparam int NUM_CH = 4;
   localparam int DEPTH  = 8;
   localparam int D5     = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic push_buffer = 1'b0;
   logic [1:0] push_ch = '0;
   logic [7:0] data_in = '0;
   logic pop_buffer = 1'b0;
   logic read_buffer = 1'b0;
   logic [1:0] rd_ch = '0;
   logic err_clear = 1'b0;

   logic [7:0] data_out, data_out5;
   logic data_valid, data_valid5;
   logic [NUM_CH-1:0][3:0] count;
   logic [NUM_CH-1:0][2:0] count5;
   logic [NUM_CH-1:0] empty, at_capacity, almost_full;
   logic [NUM_CH-1:0] empty5, at_capacity5, almost_full5;
   logic overflow, underflow, overflow5, underflow5;

   always #5 clk = ~clk;

   multi_circular_buffer #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .T(warp_reg_t)) u_dut (
      .clk(clk), .rst(rst), .push_buffer(push_buffer), .push_ch(push_ch), .data_in(data_in),
      .pop_buffer(pop_buffer), .read_buffer(read_buffer), .rd_ch(rd_ch), .err_clear(err_clear),
      .data_out(data_out), .data_valid(data_valid), .count(count), .empty(empty),
      .at_capacity(at_capacity), .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
   );

   multi_circular_buffer #(.NUM_CH(NUM_CH), .DEPTH(D5), .T(warp_reg_t)) u_dut5 (
      .clk(clk), .rst(rst), .push_buffer(push_buffer), .push_ch(push_ch), .data_in(data_in),
      .pop_buffer(pop_buffer), .read_buffer(read_buffer), .rd_ch(rd_ch), .err_clear(err_clear),
      .data_out(data_out5), .data_valid(data_valid5), .count(count5), .empty(empty5),
      .at_capacity(at_capacity5), .almost_full(almost_full5), .overflow(overflow5), .underflow(underflow5)
   );

   logic [7:0] mq [NUM_CH][$];
   logic [7:0] sb [$];
   logic [7:0] last_out = '0;
   logic m_ovf = 1'b0;
   logic m_unf = 1'b0;
   logic chk5 = 1'b0;
   int n_checks = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_cycle(input logic ps, input logic [1:0] pc, input logic [7:0] d,
                           input logic pp, input logic rd, input logic [1:0] rc, input logic clr);
      logic pop_ok, push_ok;
      push_buffer = ps; push_ch = pc; data_in = d;
      pop_buffer = pp; read_buffer = rd; rd_ch = rc; err_clear = clr;
      pop_ok  = (pp || rd) && (mq[rc].size() > 0);
      push_ok = ps && ((mq[pc].size() < DEPTH) || (pp && pc == rc && pop_ok));
      if (pop_ok) begin
         sb.push_back(mq[rc][0]);
         if (pp) void'(mq[rc].pop_front());
      end
      if (push_ok) mq[pc].push_back(d);
      m_ovf = (ps && !push_ok) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_unf = ((pp || rd) && !pop_ok) ? 1'b1 : (clr ? 1'b0 : m_unf);
      @(posedge clk);
      #1;
      check_eq("data_valid", 32'(data_valid), 32'(pop_ok));
      if (pop_ok) last_out = sb.pop_front();
      check_eq("data_out", 32'(data_out), 32'(last_out));
      for (int i = 0; i < NUM_CH; i++) begin
         check_eq($sformatf("count[%0d]", i), 32'(count[i]), 32'(mq[i].size()));
         check_eq($sformatf("empty[%0d]", i), 32'(empty[i]), 32'(mq[i].size() == 0));
         check_eq($sformatf("at_capacity[%0d]", i), 32'(at_capacity[i]), 32'(mq[i].size() == DEPTH));
         check_eq($sformatf("almost_full[%0d]", i), 32'(almost_full[i]), 32'(mq[i].size() >= DEPTH - 1));
      end
      check_eq("overflow", 32'(overflow), 32'(m_ovf));
      check_eq("underflow", 32'(underflow), 32'(m_unf));
      if (chk5) begin
         check_eq("d5_data_valid", 32'(data_valid5), 32'(pop_ok));
         check_eq("d5_data_out", 32'(data_out5), 32'(last_out));
         check_eq("d5_count0", 32'(count5[0]), 32'(mq[0].size()));
         check_eq("d5_at_capacity0", 32'(at_capacity5[0]), 32'(mq[0].size() == D5));
      end
      push_buffer = 1'b0; pop_buffer = 1'b0; read_buffer = 1'b0; err_clear = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0; push_buffer = 1'b1; push_ch = 2'd0; data_in = 8'hEE;
      pop_buffer = 1'b0; read_buffer = 1'b0; err_clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_count", 32'(count), 32'd0);
      check_eq("rst_empty", 32'(empty), 32'hF);
      check_eq("rst_at_capacity", 32'(at_capacity), 32'h0);
      check_eq("rst_almost_full", 32'(almost_full), 32'h0);
      check_eq("rst_data_valid", 32'(data_valid), 32'd0);
      check_eq("rst_data_out", 32'(data_out), 32'd0);
      check_eq("rst_overflow", 32'(overflow), 32'd0);
      check_eq("rst_underflow", 32'(underflow), 32'd0);
      for (int i = 0; i < NUM_CH; i++) mq[i].delete();
      sb.delete();
      last_out = '0; m_ovf = 1'b0; m_unf = 1'b0;
      rst = 1'b1; push_buffer = 1'b0;
   endtask

   initial begin
      do_reset();
      // Nothing was stored during reset: a read of ch0 must underflow.
      do_cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0);
      do_cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);

      // Wrap on ch0, also checked against the DEPTH=5 instance.
      chk5 = 1'b1;
      for (int k = 1; k <= 5; k++) do_cycle(1'b1, 2'd0, 8'(k), 1'b0, 1'b0, 2'd0, 1'b0);
      for (int k = 0; k < 3; k++) do_cycle(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
      for (int k = 6; k <= 8; k++) do_cycle(1'b1, 2'd0, 8'(k), 1'b0, 1'b0, 2'd0, 1'b0);
      for (int k = 0; k < 5; k++) do_cycle(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);
      check_eq("wrap_last", 32'(data_out5), 32'h08);
      chk5 = 1'b0;

      // Fill ch2, overflow, drain, underflow.
      for (int k = 1; k <= 8; k++) begin
         do_cycle(1'b1, 2'd2, 8'(k), 1'b0, 1'b0, 2'd0, 1'b0);
         if (k == 7) check_eq("af_at7", 32'(almost_full[2]), 32'd1);
      end
      check_eq("full_ch2", 32'(at_capacity), 32'h4);
      do_cycle(1'b1, 2'd2, 8'h09, 1'b0, 1'b0, 2'd0, 1'b0);
      check_eq("ovf_dropped", 32'(overflow), 32'd1);
      for (int k = 0; k < 8; k++) do_cycle(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd2, 1'b0);
      check_eq("drain_last", 32'(data_out), 32'h08);
      do_cycle(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd2, 1'b0);
      do_cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);

      // Full ch1 with simultaneous push and pop.
      for (int k = 0; k < 8; k++) do_cycle(1'b1, 2'd1, 8'(8'h20 + k), 1'b0, 1'b0, 2'd0, 1'b0);
      do_cycle(1'b1, 2'd1, 8'hAA, 1'b1, 1'b0, 2'd1, 1'b0);
      check_eq("full_pp_out", 32'(data_out), 32'h20);
      check_eq("full_pp_count", 32'(count[1]), 32'd8);
      check_eq("full_pp_ovf", 32'(overflow), 32'd0);
      for (int k = 0; k < 8; k++) do_cycle(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 2'd1, 1'b0);
      check_eq("aa_last", 32'(data_out), 32'hAA);

      // Interleave channels, then peek twice.
      do_cycle(1'b1, 2'd3, 8'h30, 1'b0, 1'b0, 2'd0, 1'b0);
      do_cycle(1'b1, 2'd0, 8'h10, 1'b1, 1'b0, 2'd3, 1'b0);
      check_eq("ilv_out", 32'(data_out), 32'h30);
      do_cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0);
      do_cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0);
      check_eq("peek_out", 32'(data_out), 32'h10);
      check_eq("peek_count", 32'(count[0]), 32'd1);

      // err_clear loses to a concurrent error, then clears alone.
      for (int k = 0; k < 8; k++) do_cycle(1'b1, 2'd2, 8'(8'h50 + k), 1'b0, 1'b0, 2'd0, 1'b0);
      do_cycle(1'b1, 2'd2, 8'h99, 1'b1, 1'b0, 2'd1, 1'b1);
      check_eq("clr_race_ovf", 32'(overflow), 32'd1);
      check_eq("clr_race_unf", 32'(underflow), 32'd1);
      do_cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1);
      check_eq("clr_ovf", 32'(overflow), 32'd0);

      // Random mix against the model.
      for (int k = 0; k < 300; k++) begin
         do_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 7) == 0));
      end

      // Reset mid-operation discards strobes and clears state.
      do_reset();
      do_cycle(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multi_circular_buffer.md
# multi_circular_buffer

Parametrised multi-channel successor to the single-queue warp circular buffer: NUM_CH independent ring queues sharing one write port and one read port, each with its own head/tail pointers and occupancy count. It sits between the warp dispatcher (push side) and the warp scheduler (pop/read side), holding one queue per SM lane group. It adds per-channel status, simultaneous push/pop on a full channel, non-power-of-2 depth, and sticky overflow/underflow error flags.

## Interface
- NUM_CH, 4, number of independent queues (≥1)
- DEPTH, 8, entries per queue (≥2, any integer, not restricted to powers of 2)
- T, logic [7:0], entry type (type parameter)
- AF_LEVEL, DEPTH-1, occupancy at or above which almost_full asserts
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset (rst=0 at a rising edge resets)
- push_buffer  in  1  write strobe
- push_ch  in  CHW=$clog2(NUM_CH) (min 1)  target channel of push
- data_in  in  T  write data
- pop_buffer  in  1  read-and-remove strobe
- read_buffer  in  1  read-without-remove (peek) strobe
- rd_ch  in  CHW  channel for pop/read
- err_clear  in  1  clears overflow/underflow
- data_out  out  T  registered head entry of rd_ch
- data_valid  out  1  data_out updated by a successful pop/read last cycle
- count  out  [NUM_CH-1:0][CW-1:0], CW=$clog2(DEPTH+1)  per-channel occupancy
- empty  out  NUM_CH  count==0
- at_capacity  out  NUM_CH  count==DEPTH
- almost_full  out  NUM_CH  count≥AF_LEVEL
- overflow  out  1  sticky: push to full channel dropped
- underflow  out  1  sticky: pop/read of empty channel

## Operation
- Reset (rst=0): all head/tail pointers and counts to 0; data_out='0; data_valid=0; overflow=underflow=0; empty=all 1s; at_capacity=almost_full=0 (almost_full=all 1s only if AF_LEVEL==0). Storage contents not reset.
- Push: if push_buffer and channel push_ch not full, mem[push_ch][tail] <= data_in, tail advances, count+1.
- Pop: if pop_buffer and rd_ch non-empty, data_out <= mem[rd_ch][head], head advances, count−1, data_valid=1 next cycle.
- Read: if read_buffer (pop_buffer low) and rd_ch non-empty, data_out <= head entry, no pointer/count change, data_valid=1.
- pop_buffer and read_buffer both high: treated as pop.
- Pop/read of empty channel: data_out holds, data_valid=0, underflow set.
- Push to full channel with no same-channel pop: data dropped, state unchanged, overflow set.
- Push and pop same channel, same cycle: both performed, count unchanged; allowed when full (push accepted, no overflow). When empty: pop underflows, push accepted (no bypass; data_out does not see data_in).
- Push and pop different channels: fully independent.
- Pointer wrap: pointer == DEPTH-1 advances to 0 (explicit compare, not modulo-2^n).
- err_clear clears both sticky flags; a new error in the same cycle wins (flag stays 1).
- push_ch/rd_ch ≥ NUM_CH: operation ignored, overflow (push) / underflow (pop/read) set.

## Timing
- Single clock; every output is a register or a pure decode of count registers.
- Push-to-visible latency: entry poppable the cycle after push edge; count/flags update on same edge.
- Pop/read latency: 1 cycle, data_out/data_valid valid after the strobe's edge; data_valid is a one-cycle pulse per successful op.
- Back-to-back pops on one channel sustain one entry per cycle.
- Reset mid-operation: takes effect on the sampling edge regardless of strobes; strobes that cycle are discarded.

## Structure
- Shared package gpu_buffer_pkg: default warp_reg_t typedef, helper function for CHW/CW width computation.
- One sub-module: ring_channel (single queue: storage, head/tail, count, full/empty, wrap), instantiated NUM_CH times via generate; top does channel decode, output mux, data_out register, error flags.

## Test plan
- Reset: hold rst=0 two cycles with push_buffer=1 -> all counts 0, empty=4'b1111, data_valid=0, no entry stored.
- Fill ch2 with 8'h01..8'h08 -> count[2]=8, at_capacity=4'b0100, almost_full[2] set at count 7; 9th push 8'h09 dropped, overflow=1; pops return 01..08 in order, then pop -> underflow=1, data_valid=0.
- Wrap, DEPTH=5 build: push 5, pop 3, push 3 on ch0 -> count 5, pops return entries 4,5,6,7,8 in order across wrap.
- Full ch1 with simultaneous push 8'hAA and pop -> data_out=oldest entry, count stays 8, overflow stays 0, AA popped last.
- Interleave: push ch0 8'h10 and pop ch3 (holding 8'h30) same cycle -> data_out=8'h30, count[0]=1, count[3]=0; read_buffer on ch0 twice -> 8'h10 both times, count[0] unchanged.
- err_clear with concurrent overflow -> overflow remains 1; next cycle err_clear alone -> 0.
